branch_target_buffer: RTL and testbench

//  - Direct-mapped BTB in the fetch unit. Answers same-cycle lookups for the fetch PC.
//  - Drives btbHit/btbPredictedPc into next-PC generation.
//  - Accepts resolved-branch updates from execute through a 2-entry update queue.
//  - Clears itself entry by entry after reset.

---
 rtl/branch_target_buffer.sv | 143 ++++++++++++++
 tb/tb_branch_target_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-entry update queue and post-reset table clear.
// Optional BTB_2BIT_COUNTER_EN adds a per-entry 2-bit saturating taken counter gating hits.
module branch_target_buffer #(
  parameter int unsigned ENTRY_NUM  = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [ADDR_WIDTH-1:0] lookupPc,
  output logic                  btbHit,
  output logic [ADDR_WIDTH-1:0] btbPredictedPc,
  input  logic                  updValid,
  output logic                  updReady,
  input  logic [ADDR_WIDTH-1:0] updPc,
  input  logic [ADDR_WIDTH-1:0] updTarget,
  input  logic                  updTaken,
  output logic                  initBusy
);

  localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
  localparam int unsigned TAG_W = ADDR_WIDTH - 2 - IDX_W;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                r_state, w_state_next;
  logic [IDX_W-1:0]      r_clr_idx;

  logic [ENTRY_NUM-1:0]  r_valid;
  logic [TAG_W-1:0]      r_tag    [ENTRY_NUM];
  logic [ADDR_WIDTH-1:0] r_target [ENTRY_NUM];
`ifdef BTB_2BIT_COUNTER_EN
  logic [1:0]            r_ctr    [ENTRY_NUM];
`endif

  logic [ADDR_WIDTH-1:0] r_q_pc    [2];
  logic [ADDR_WIDTH-1:0] r_q_tgt   [2];
  logic                  r_q_taken [2];
  logic [1:0]            r_count;

  logic                  w_push, w_pop, w_slot;
  logic [IDX_W-1:0]      w_head_idx, w_lk_idx;
  logic [TAG_W-1:0]      w_head_tag, w_lk_tag;
  logic                  w_head_match, w_hit;
  logic                  w_unused_pc_lsbs;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state   <= StInit;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StInit) r_clr_idx <= r_clr_idx + IDX_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInit:  if (r_clr_idx == IDX_W'(ENTRY_NUM - 1)) w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StInit;
    endcase
  end

  assign initBusy = (r_state == StInit);
  assign updReady = (r_count < 2'd2);
  assign w_push   = updValid & updReady;
  assign w_pop    = (r_state == StRun) & (r_count != 2'd0);
  // A push never sees a full queue, so with a pop it lands in slot 0.
  assign w_slot   = w_pop ? 1'b0 : r_count[0];

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_q_pc[0]    <= r_q_pc[1];
        r_q_tgt[0]   <= r_q_tgt[1];
        r_q_taken[0] <= r_q_taken[1];
      end
      if (w_push) begin
        r_q_pc[w_slot]    <= updPc;
        r_q_tgt[w_slot]   <= updTarget;
        r_q_taken[w_slot] <= updTaken;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  assign w_head_idx   = r_q_pc[0][IDX_W+1:2];
  assign w_head_tag   = r_q_pc[0][ADDR_WIDTH-1:IDX_W+2];
  assign w_head_match = r_valid[w_head_idx] & (r_tag[w_head_idx] == w_head_tag);

  always_ff @(posedge clk) begin
    if (rstN) begin
      if (r_state == StInit) begin
        r_valid[r_clr_idx] <= 1'b0;
`ifdef BTB_2BIT_COUNTER_EN
        r_ctr[r_clr_idx]   <= 2'd0;
`endif
      end else if (w_pop) begin
`ifdef BTB_2BIT_COUNTER_EN
        if (r_q_taken[0]) begin
          r_target[w_head_idx] <= r_q_tgt[0];
          if (w_head_match) begin
            if (r_ctr[w_head_idx] != 2'd3) r_ctr[w_head_idx] <= r_ctr[w_head_idx] + 2'd1;
          end else begin
            r_valid[w_head_idx] <= 1'b1;
            r_tag[w_head_idx]   <= w_head_tag;
            r_ctr[w_head_idx]   <= 2'd2;
          end
        end else if (w_head_match && r_ctr[w_head_idx] != 2'd0) begin
          r_ctr[w_head_idx] <= r_ctr[w_head_idx] - 2'd1;
        end
`else
        if (r_q_taken[0]) begin
          r_valid[w_head_idx]  <= 1'b1;
          r_tag[w_head_idx]    <= w_head_tag;
          r_target[w_head_idx] <= r_q_tgt[0];
        end else if (w_head_match) begin
          r_valid[w_head_idx] <= 1'b0;
        end
`endif
      end
    end
  end

  assign w_lk_idx = lookupPc[IDX_W+1:2];
  assign w_lk_tag = lookupPc[ADDR_WIDTH-1:IDX_W+2];

  always_comb begin
    w_hit = (r_state == StRun) & r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);
`ifdef BTB_2BIT_COUNTER_EN
    w_hit = w_hit & r_ctr[w_lk_idx][1];
`endif
  end

  assign btbHit         = w_hit;
  assign btbPredictedPc = w_hit ? r_target[w_lk_idx] : '0;

  assign w_unused_pc_lsbs = ^{lookupPc[1:0], updPc[1:0], r_q_pc[0][1:0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized self-checking bench for branch_target_buffer against a table/queue reference model.
// Honours BTB_2BIT_COUNTER_EN the same way as the design.
module tb_branch_target_buffer;

  localparam int unsigned N     = 64;
  localparam int unsigned IDX_W = 6;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [31:0] lookupPc = '0;
  logic        btbHit;
  logic [31:0] btbPredictedPc;
  logic        updValid = 1'b0;
  logic        updReady;
  logic [31:0] updPc = '0;
  logic [31:0] updTarget = '0;
  logic        updTaken = 1'b0;
  logic        initBusy;

  branch_target_buffer #(.ENTRY_NUM(64), .ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .lookupPc       (lookupPc),
    .btbHit         (btbHit),
    .btbPredictedPc (btbPredictedPc),
    .updValid       (updValid),
    .updReady       (updReady),
    .updPc          (updPc),
    .updTarget      (updTarget),
    .updTaken       (updTaken),
    .initBusy       (initBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
  } upd_t;

  // Reference model: a plain table plus an unbounded queue capped at 2 by the accept rule.
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  upd_t        mq[$];
  int          m_init_left = N;
  bit          m_chk_on = 0;
  bit          m_last_accept = 0;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned f_idx(input logic [31:0] pc);
    return (pc >> 2) % N;
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] pc);
    return pc >> (2 + IDX_W);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int unsigned i;
    i = f_idx(pc);
    if (m_init_left > 0) return 0;
`ifdef BTB_2BIT_COUNTER_EN
    return m_valid[i] && m_tag[i] == f_tag(pc) && m_ctr[i] >= 2;
`else
    return m_valid[i] && m_tag[i] == f_tag(pc);
`endif
  endfunction

  task automatic m_apply(input upd_t u);
    int unsigned i;
    bit match;
    i = f_idx(u.pc);
    match = m_valid[i] && m_tag[i] == f_tag(u.pc);
`ifdef BTB_2BIT_COUNTER_EN
    if (u.taken) begin
      m_tgt[i] = u.tgt;
      if (match) m_ctr[i] = (m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1;
      else begin
        m_valid[i] = 1;
        m_tag[i]   = f_tag(u.pc);
        m_ctr[i]   = 2;
      end
    end else if (match) begin
      m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
    end
`else
    if (u.taken) begin
      m_valid[i] = 1;
      m_tag[i]   = f_tag(u.pc);
      m_tgt[i]   = u.tgt;
    end else if (match) begin
      m_valid[i] = 0;
    end
`endif
  endtask

  task automatic m_edge();
    upd_t u;
    bit accept;
    m_last_accept = 0;
    if (!rstN) begin
      // Nothing can be written during the clear, so wiping the table here is equivalent.
      m_init_left = N;
      mq.delete();
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      return;
    end
    accept = updValid && mq.size() < 2;
    if (m_init_left == 0 && mq.size() > 0) begin
      u = mq.pop_front();
      m_apply(u);
    end
    if (accept) begin
      u.pc = updPc; u.tgt = updTarget; u.taken = updTaken;
      mq.push_back(u);
      m_last_accept = 1;
    end
    if (m_init_left > 0) m_init_left--;
  endtask

  task automatic cyc(input logic [31:0] lpc, input logic v, input logic [31:0] upc,
                     input logic [31:0] utgt, input logic utk, input logic rn);
    bit h;
    lookupPc = lpc; updValid = v; updPc = upc; updTarget = utgt; updTaken = utk; rstN = rn;
    #1;
    if (m_chk_on) begin
      h = m_hit(lpc);
      check_eq("hit", {31'd0, btbHit}, {31'd0, h});
      check_eq("pred_pc", btbPredictedPc, h ? m_tgt[f_idx(lpc)] : 32'd0);
      check_eq("init_busy", {31'd0, initBusy}, {31'd0, m_init_left > 0});
      check_eq("upd_ready", {31'd0, updReady}, {31'd0, mq.size() < 2});
    end
    @(posedge clk);
    m_edge();
    m_chk_on = 1;
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] lpc);
    cyc(lpc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    cyc(32'd0, 1'b1, pc, tgt, tk, 1'b1);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic eh,
                      input logic [31:0] et);
    lookupPc = pc; updValid = 1'b0; rstN = 1'b1;
    #1;
    check_eq({tag, "_hit"}, {31'd0, btbHit}, {31'd0, eh});
    check_eq({tag, "_pc"}, btbPredictedPc, et);
    idle(pc);
  endtask

  task automatic wait_init();
    for (int k = 0; k < 200 && m_init_left > 0; k++) idle(k[0] ? 32'h1000 : 32'h0);
  endtask

  logic [31:0] pool [8];

  initial begin
    int n;
    logic [31:0] pc, tg;

    // Reset then measure the clear phase
    cyc(32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc(32'h1000, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_eq("rst_busy", {31'd0, initBusy}, 32'd1);
    check_eq("rst_ready", {31'd0, updReady}, 32'd1);
    n = 0;
    for (int k = 0; k < 200 && initBusy === 1'b1; k++) begin
      n++;
      idle(k[0] ? 32'h1000 : 32'h0);
    end
    check_eq("init_len", n, 32'd64);

    // Taken update and lookup latency
    push(32'h1000, 32'h2000, 1'b1);
    look("lat_e1", 32'h1000, 1'b0, 32'h0);
    look("tk_1000", 32'h1000, 1'b1, 32'h2000);
    look("tk_1004", 32'h1004, 1'b0, 32'h0);
    look("tk_1002", 32'h1002, 1'b1, 32'h2000);

    // Alias on index 0
    push(32'h1100, 32'h3000, 1'b1);
    idle(32'h0);
    look("al_1100", 32'h1100, 1'b1, 32'h3000);
    look("al_1000", 32'h1000, 1'b0, 32'h0);

    // Not taken after taken, then taken again
    push(32'h1000, 32'h2000, 1'b1);
    push(32'h1000, 32'h0, 1'b0);
    idle(32'h0);
    idle(32'h0);
    look("nt_1000", 32'h1000, 1'b0, 32'h0);
    push(32'h1000, 32'h2000, 1'b1);
    idle(32'h0);
    look("nt_retk", 32'h1000, 1'b1, 32'h2000);

    // Backpressure while clearing
    cyc(32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    push(32'h40, 32'h80, 1'b1);
    push(32'h44, 32'h88, 1'b1);
    check_eq("bp_ready", {31'd0, updReady}, 32'd0);
    m_last_accept = 0;
    for (int k = 0; k < 100 && !m_last_accept; k++) push(32'h48, 32'h90, 1'b1);
    check_eq("bp_accept", {31'd0, m_last_accept}, 32'd1);
    idle(32'h0);
    look("bp_40", 32'h40, 1'b1, 32'h80);
    look("bp_44", 32'h44, 1'b1, 32'h88);
    look("bp_48", 32'h48, 1'b1, 32'h90);

    // Reset with two queued updates
    cyc(32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    push(32'h200, 32'h600, 1'b1);
    push(32'h204, 32'h604, 1'b1);
    cyc(32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_eq("rq_ready", {31'd0, updReady}, 32'd1);
    wait_init();
    for (int k = 0; k < 4; k++) idle(32'h0);
    look("rq_200", 32'h200, 1'b0, 32'h0);
    look("rq_204", 32'h204, 1'b0, 32'h0);

    // Random traffic over a small PC pool so aliasing and hits are frequent
    pool[0] = 32'h1000; pool[1] = 32'h1100; pool[2] = 32'h40;   pool[3] = 32'h44;
    pool[4] = 32'h2000; pool[5] = 32'h3004; pool[6] = 32'h10fc; pool[7] = 32'h80;
    for (int k = 0; k < 3000; k++) begin
      pc = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      tg = {$urandom_range(0, 255), 2'b00};
      cyc($urandom_range(0, 3) == 0 ? pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)) : pc,
          $urandom_range(0, 2) != 0, pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
          tg, $urandom_range(0, 3) != 0, $urandom_range(0, 499) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
